// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the sensor/keypad front end and the parking gate controller.
// master drives the sensors and keypad; slave is the controller.
interface parking_gate_ctrl_if #(
  parameter int unsigned PW_WIDTH = 4,
  parameter int unsigned CNT_W    = 5
);
  logic                sensor_entrance;
  logic                sensor_exit;
  logic                car_depart;
  logic                pw_valid;
  logic [PW_WIDTH-1:0] pw_in;
  logic                green_led;
  logic                red_led;
  logic                lot_full;
  logic [CNT_W-1:0]    occupancy;
  logic [2:0]          state;
  logic                alarm;

  modport master (
    output sensor_entrance, sensor_exit, car_depart, pw_valid, pw_in,
    input  green_led, red_led, lot_full, occupancy, state, alarm
  );

  modport slave (
    input  sensor_entrance, sensor_exit, car_depart, pw_valid, pw_in,
    output green_led, red_led, lot_full, occupancy, state, alarm
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Multi-slot parking entry gate: password check, occupancy tracking, entry timeout, tailgate alarm.
// Define PARKING_LOCKOUT_EN to build the wrong-password counter and the LOCKED state.
module parking_gate_ctrl #(
  parameter int unsigned          CAPACITY    = 16,
  parameter int unsigned          PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0]  PASSWORD    = 4'b0110,
  parameter int unsigned          TIMEOUT_CYC = 1000,
  parameter int unsigned          MAX_TRIES   = 3,
  parameter int unsigned          LOCK_CYC    = 5000
) (
  input  logic               clk,
  input  logic               reset_n,
  parking_gate_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CAPACITY + 1);
`ifdef PARKING_LOCKOUT_EN
  localparam int unsigned TMR_MAX = (LOCK_CYC > TIMEOUT_CYC) ? LOCK_CYC : TIMEOUT_CYC;
  localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
`else
  localparam int unsigned TMR_MAX = TIMEOUT_CYC;
`endif
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

  if (CAPACITY < 1 || TIMEOUT_CYC < 2 || MAX_TRIES < 1 || LOCK_CYC < 1) begin : g_bad_param
    $error("parking_gate_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitPass  = 3'd1,
    StWrongPass = 3'd2,
    StRightPass = 3'd3,
    StStop      = 3'd4,
    StLocked    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
`ifdef PARKING_LOCKOUT_EN
  logic [TRY_W-1:0] tries_q, tries_d;
`endif

  logic lot_full;
  logic pw_ok;
  logic occ_inc;
  logic green, red, alarm;

  assign lot_full = (occ_q == CNT_W'(CAPACITY));
  assign pw_ok    = bus.pw_valid && (bus.pw_in == PASSWORD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
    end
  end

`ifdef PARKING_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tries_q <= '0;
    end else begin
      tries_q <= tries_d;
    end
  end
`endif

  // Timer only runs while waiting for a password or while locked; every other path zeroes it.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
`ifdef PARKING_LOCKOUT_EN
    tries_d = tries_q;
`endif
    occ_inc = 1'b0;
    green   = 1'b0;
    red     = 1'b0;
    alarm   = 1'b0;
    case (state_q)
      StIdle: begin
        red = lot_full;
        if (bus.sensor_entrance && !lot_full) begin
          state_d = StWaitPass;
        end
      end
      StWaitPass, StWrongPass: begin
        red = 1'b1;
        if (pw_ok) begin
          state_d = StRightPass;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end else if (bus.pw_valid) begin
`ifdef PARKING_LOCKOUT_EN
          tries_d = tries_q + 1'b1;
          state_d = (tries_q == TRY_W'(MAX_TRIES - 1)) ? StLocked : StWrongPass;
`else
          state_d = StWrongPass;
`endif
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRightPass: begin
        green = 1'b1;
        if (bus.sensor_entrance && bus.sensor_exit) begin
          state_d = StStop;
        end else if (bus.sensor_exit) begin
          state_d = StIdle;
          occ_inc = 1'b1;
        end
      end
      StStop: begin
        red   = 1'b1;
        alarm = 1'b1;
        if (pw_ok) begin
          state_d = StRightPass;
        end
      end
`ifdef PARKING_LOCKOUT_EN
      StLocked: begin
        red   = 1'b1;
        alarm = 1'b1;
        if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
          state_d = StIdle;
          tries_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Saturating occupancy; an arrival and a departure in the same cycle cancel.
  always_comb begin
    occ_d = occ_q;
    if (occ_inc && !bus.car_depart && !lot_full) begin
      occ_d = occ_q + 1'b1;
    end else if (bus.car_depart && !occ_inc && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  assign bus.green_led = green;
  assign bus.red_led   = red;
  assign bus.alarm     = alarm;
  assign bus.lot_full  = lot_full;
  assign bus.occupancy = occ_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: a directed vector table plus hand-written
// sequences for timeout, lockout, full lot and asynchronous reset.
module tb_parking_gate_ctrl;

  logic clk;
  logic reset_n;

  parking_gate_ctrl_if #(.PW_WIDTH(4), .CNT_W(5)) bus ();

  parking_gate_ctrl #(
    .CAPACITY   (16),
    .PW_WIDTH   (4),
    .PASSWORD   (4'b0110),
    .TIMEOUT_CYC(1000),
    .MAX_TRIES  (3),
    .LOCK_CYC   (5000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ent, ex, dep, pv;
    logic [3:0] pw;
    logic [2:0] st;
    logic       g, r, a;
    logic [4:0] occ;
    logic       full;
  } vec_t;

  int n_pass;
  int n_total;
  int cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input logic ent, input logic ex, input logic dep, input logic pv,
                      input logic [3:0] pw);
    @(negedge clk);
    bus.sensor_entrance = ent;
    bus.sensor_exit     = ex;
    bus.car_depart      = dep;
    bus.pw_valid        = pv;
    bus.pw_in           = pw;
    @(posedge clk);
    #1;
  endtask

  task automatic enter_car();
    tick(1, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b0110);
    tick(0, 1, 0, 0, 4'b0000);
  endtask

  function automatic vec_t mk(input logic ent, input logic ex, input logic dep, input logic pv,
                              input logic [3:0] pw, input logic [2:0] st, input logic g,
                              input logic r, input logic a, input logic [4:0] occ,
                              input logic full);
    vec_t v;
    v.ent = ent; v.ex = ex; v.dep = dep; v.pv = pv; v.pw = pw;
    v.st = st; v.g = g; v.r = r; v.a = a; v.occ = occ; v.full = full;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    n_pass  = 0;
    n_total = 0;
    //           ent ex dep pv pw       st g r a occ full
    vecs[0]  = mk(1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 0, 0);  // entrance -> WAIT_PASS
    vecs[1]  = mk(0, 0, 0, 1, 4'b0110, 3, 1, 0, 0, 0, 0);  // right password
    vecs[2]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0);  // car through
    vecs[3]  = mk(1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 4'b0000, 2, 0, 1, 0, 1, 0);  // wrong password
    vecs[5]  = mk(0, 0, 0, 1, 4'b0110, 3, 1, 0, 0, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0, 4'b0000, 4, 0, 1, 1, 1, 0);  // tailgate
    vecs[7]  = mk(0, 0, 0, 1, 4'b0000, 4, 0, 1, 1, 1, 0);  // wrong ignored in STOP
    vecs[8]  = mk(0, 0, 0, 1, 4'b0110, 3, 1, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 1, 0);  // arrival + departure cancel
    vecs[10] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);  // departure at 0 saturates
    vecs[12] = mk(1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 4'b0001, 2, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 4'b0110, 3, 1, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0);

    reset_n             = 1'b0;
    bus.sensor_entrance = 1'b0;
    bus.sensor_exit     = 1'b0;
    bus.car_depart      = 1'b0;
    bus.pw_valid        = 1'b0;
    bus.pw_in           = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {29'd0, bus.state, bus.green_led, bus.red_led, bus.alarm, bus.lot_full, bus.occupancy},
          32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].ent, vecs[i].ex, vecs[i].dep, vecs[i].pv, vecs[i].pw);
      check($sformatf("vec%0d", i),
            {20'd0, bus.state, bus.green_led, bus.red_led, bus.alarm, bus.occupancy,
             bus.lot_full},
            {20'd0, vecs[i].st, vecs[i].g, vecs[i].r, vecs[i].a, vecs[i].occ, vecs[i].full});
    end

    // Timeout: 1000 cycles in WAIT_PASS, then IDLE.
    tick(1, 0, 0, 0, 4'b0000);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      tick(0, 0, 0, 0, 4'b0000);
      if (bus.state == 3'd1) cnt++;
      else break;
    end
    check("timeout_cycles", cnt, 1000);
    check("timeout_state", bus.state, 3'd0);

    // Wrong password restarts the timer.
    tick(1, 0, 0, 0, 4'b0000);
    repeat (499) tick(0, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b1111);
    check("restart_state", bus.state, 3'd2);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      tick(0, 0, 0, 0, 4'b0000);
      if (bus.state == 3'd2) cnt++;
      else break;
    end
    check("restart_cycles", cnt, 1000);

    // Three wrong passwords.
    tick(1, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b0000);
    tick(0, 0, 0, 1, 4'b0001);
    tick(0, 0, 0, 1, 4'b0010);
`ifdef PARKING_LOCKOUT_EN
    check("lock_state", bus.state, 3'd5);
    check("lock_alarm", bus.alarm, 1'b1);
    cnt = 1;
    for (int i = 0; i < 6000; i++) begin
      tick(1, 0, 0, 0, 4'b0000);
      if (bus.state == 3'd5) cnt++;
      else break;
    end
    check("lock_cycles", cnt, 5000);
    check("lock_exit_state", bus.state, 3'd0);
    tick(0, 0, 0, 0, 4'b0000);
`else
    check("third_wrong_state", bus.state, 3'd2);
    check("third_wrong_alarm", bus.alarm, 1'b0);
    repeat (1000) tick(0, 0, 0, 0, 4'b0000);
`endif
    check("after_tries_state", bus.state, 3'd0);

    // Fill the lot from 1 to 15, then arrival + departure at 15, then the 16th car.
    for (int i = 0; i < 14; i++) enter_car();
    check("occ15", bus.occupancy, 5'd15);
    tick(1, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b0110);
    tick(0, 1, 1, 0, 4'b0000);
    check("cancel_at15", bus.occupancy, 5'd15);
    enter_car();
    check("full_occ", bus.occupancy, 5'd16);
    check("full_flag", bus.lot_full, 1'b1);
    tick(1, 0, 0, 0, 4'b0000);
    check("full_blocks", {bus.state, bus.red_led}, {3'd0, 1'b1});

    // Tailgate, then asynchronous reset mid-STOP.
    tick(0, 0, 1, 0, 4'b0000);
    check("depart_from_full", {bus.occupancy, bus.lot_full}, {5'd15, 1'b0});
    tick(1, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b0110);
    tick(1, 1, 0, 0, 4'b0000);
    check("stop_state", {bus.state, bus.alarm}, {3'd4, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset",
          {20'd0, bus.state, bus.green_led, bus.red_led, bus.alarm, bus.lot_full, bus.occupancy},
          32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
